// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, parity
// selector constants and a small elaboration-time helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4,
        ST_GAP   = 3'd5
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Largest of three values, used to size the per-phase bit index.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: o_tick marks the last clock of every bit period,
// o_pre_tick the clock before it. i_restart aligns a new bit period to
// the next clock so a frame's start bit gets a full CLKS_PER_BIT cycles.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick,
    output logic o_pre_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

    logic [CNT_W-1:0] r_cnt;

    // Free-running modulo-CLKS_PER_BIT counter, zeroed on restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick     = (r_cnt == LAST);
    // With a one-cycle bit there is no "cycle before the tick".
    assign o_pre_tick = (CLKS_PER_BIT > 1) && !i_restart && (r_cnt == PRE);

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter with a stream input (valid/ready) and a built-in
// incrementing test-pattern source. Frame: start, DATA_BITS LSB first,
// optional parity, STOP stop bits, then GAP_BITS idle bit-times.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 33330000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP        = 1,
    parameter int GAP_BITS    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 serial_tx,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          byte_count
);

    localparam int  CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int  MAX_BITS     = max3(DATA_BITS, STOP, GAP_BITS);
    localparam int  IDX_W        = $clog2(MAX_BITS + 1);
    localparam bit  HAS_PAR      = (PARITY != PAR_NONE);
    localparam bit  HAS_GAP      = (GAP_BITS > 0);

    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP - 1);
    localparam logic [IDX_W-1:0] LAST_GAP  = IDX_W'(HAS_GAP ? GAP_BITS - 1 : 0);

    uart_state_t            r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_tx;
    logic                   r_final;
    logic                   r_frame_done;
    logic [15:0]            r_count;
    logic [DATA_BITS-1:0]   r_pattern;
    logic                   r_pat_frame;

    logic                   w_tick;
    logic                   w_pre_tick;
    logic                   w_start;
    logic [DATA_BITS-1:0]   w_load;

    // Parity bit making the total count of ones odd or even.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == PAR_ODD) ? ~^d : ^d;
    endfunction

    // Frame counter that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // True for the (state, index) pair that is the very last bit-time of
    // a frame: the last gap bit when a gap exists, else the last stop bit.
    function automatic logic is_final(input uart_state_t st, input logic [IDX_W-1:0] idx);
        if (HAS_GAP) begin
            return (st == ST_GAP) && (idx == LAST_GAP);
        end
        return (st == ST_STOP) && (idx == LAST_STOP);
    endfunction

    // mode/enable only matter here because s_ready and w_start are gated
    // by ST_IDLE; a frame in flight never looks at them.
    assign s_ready    = !rst && (r_state == ST_IDLE) && !mode;
    assign w_start    = (r_state == ST_IDLE) && (mode ? enable : s_valid);
    assign w_load     = mode ? r_pattern : s_data;
    assign busy       = (r_state != ST_IDLE);
    assign serial_tx  = r_tx;
    assign byte_count = r_count;
    // With one-cycle bits the final bit-time is a single cycle, so the
    // final-bit flag itself is the pulse; otherwise it is pre-registered
    // from the cycle before the last tick.
    assign frame_done = (CLKS_PER_BIT == 1) ? r_final : r_frame_done;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .rst        (rst),
        .i_restart  (w_start),
        .o_tick     (w_tick),
        .o_pre_tick (w_pre_tick)
    );

    // Frame payload: latched at acceptance, shifted out LSB first.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_shift <= w_load;
            r_par   <= parity_of(w_load);
        end else if (w_tick && ((r_state == ST_START) || (r_state == ST_DATA))) begin
            r_shift <= r_shift >> 1;
        end
    end

    // Frame sequencer: walks the line bits one baud tick at a time and
    // registers the line level, frame-end pulse and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_tx         <= 1'b1;
            r_final      <= 1'b0;
            r_frame_done <= 1'b0;
            r_count      <= 16'd0;
            r_pattern    <= DATA_BITS'(1);
            r_pat_frame  <= 1'b0;
        end else begin
            r_frame_done <= r_final && w_pre_tick;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state     <= ST_START;
                        r_tx        <= 1'b0;
                        r_idx       <= '0;
                        r_pat_frame <= mode;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                        r_idx   <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_idx == LAST_DATA) begin
                            r_idx <= '0;
                            if (HAS_PAR) begin
                                r_state <= ST_PAR;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= ST_STOP;
                                r_tx    <= 1'b1;
                                r_final <= is_final(ST_STOP, '0);
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            r_tx  <= r_shift[0];
                        end
                    end
                end
                ST_PAR: begin
                    if (w_tick) begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                        r_idx   <= '0;
                        r_final <= is_final(ST_STOP, '0);
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_idx != LAST_STOP) begin
                            r_idx   <= r_idx + 1'b1;
                            r_final <= is_final(ST_STOP, r_idx + 1'b1);
                        end else if (HAS_GAP) begin
                            r_state <= ST_GAP;
                            r_idx   <= '0;
                            r_final <= is_final(ST_GAP, '0);
                        end else begin
                            r_state <= ST_IDLE;
                            r_idx   <= '0;
                            r_final <= 1'b0;
                            r_count <= sat_inc(r_count);
                            if (r_pat_frame) begin
                                r_pattern <= r_pattern + 1'b1;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        if (r_idx != LAST_GAP) begin
                            r_idx   <= r_idx + 1'b1;
                            r_final <= is_final(ST_GAP, r_idx + 1'b1);
                        end else begin
                            r_state <= ST_IDLE;
                            r_idx   <= '0;
                            r_final <= 1'b0;
                            r_count <= sat_inc(r_count);
                            if (r_pat_frame) begin
                                r_pattern <= r_pattern + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_final <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream: five parameterisations share one
// stimulus set (1000 Hz clock, 100 baud -> 10 clocks per bit).
module tb_uart_tx_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       mode;
    logic       enable;
    logic       s_valid;
    logic [7:0] s_data;

    logic        txv  [5];
    logic        rdy  [5];
    logic        bsy  [5];
    logic        fdn  [5];
    logic [15:0] bcnt [5];

    int checks = 0;
    int errors = 0;

    logic l_tx  [0:2599];
    logic l_fd  [0:2599];
    logic l_bsy [0:2599];
    logic l_rdy [0:2599];
    logic e_tx  [0:2599];

    uart_tx_stream #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP(1), .GAP_BITS(0)) u_8n1 (
        .clk(clk), .rst(rst), .mode(mode), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy[0]), .serial_tx(txv[0]), .busy(bsy[0]), .frame_done(fdn[0]), .byte_count(bcnt[0]));

    uart_tx_stream #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP(2), .GAP_BITS(0)) u_8o2 (
        .clk(clk), .rst(rst), .mode(mode), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy[1]), .serial_tx(txv[1]), .busy(bsy[1]), .frame_done(fdn[1]), .byte_count(bcnt[1]));

    uart_tx_stream #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP(2), .GAP_BITS(0)) u_8e2 (
        .clk(clk), .rst(rst), .mode(mode), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy[2]), .serial_tx(txv[2]), .busy(bsy[2]), .frame_done(fdn[2]), .byte_count(bcnt[2]));

    uart_tx_stream #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .DATA_BITS(5), .PARITY(0), .STOP(1), .GAP_BITS(0)) u_5n1 (
        .clk(clk), .rst(rst), .mode(mode), .enable(enable), .s_data(s_data[4:0]), .s_valid(s_valid),
        .s_ready(rdy[3]), .serial_tx(txv[3]), .busy(bsy[3]), .frame_done(fdn[3]), .byte_count(bcnt[3]));

    uart_tx_stream #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP(1), .GAP_BITS(2)) u_gap (
        .clk(clk), .rst(rst), .mode(mode), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy[4]), .serial_tx(txv[4]), .busy(bsy[4]), .frame_done(fdn[4]), .byte_count(bcnt[4]));

    // Record outputs of DUT u on each of the next n falling edges (index 1..n).
    task automatic sample_line(input int u, input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            l_tx[k]  = txv[u];
            l_fd[k]  = fdn[u];
            l_bsy[k] = bsy[u];
            l_rdy[k] = rdy[u];
        end
    endtask

    task automatic clear_exp();
        for (int k = 0; k < 2600; k++) e_tx[k] = 1'b1;
    endtask

    // Expected line levels of one frame starting at cycle 'at', 10 cycles per bit.
    task automatic put_frame(input logic [7:0] b, input int nb, input int par, input int nst,
                             input int at, output int last);
        logic bits [0:11];
        int n;
        int ones;
        n = 0;
        ones = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin
            bits[n] = b[i]; ones += int'(b[i]); n++;
        end
        if (par == 1) begin bits[n] = (ones % 2 == 0); n++; end
        else if (par == 2) begin bits[n] = (ones % 2 == 1); n++; end
        for (int i = 0; i < nst; i++) begin bits[n] = 1'b1; n++; end
        for (int i = 0; i < n; i++)
            for (int c = 0; c < 10; c++) e_tx[at + i*10 + c] = bits[i];
        last = at + n*10 - 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; mode = 1'b0; enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        @(negedge clk); #1;
        for (int u = 0; u < 5; u++) begin
            checks++; if (txv[u] !== 1'b1) begin errors++; $display("FAIL reset_tx u%0d got %b want 1", u, txv[u]); end
            checks++; if (bsy[u] !== 1'b0) begin errors++; $display("FAIL reset_busy u%0d got %b want 0", u, bsy[u]); end
            checks++; if (fdn[u] !== 1'b0) begin errors++; $display("FAIL reset_fd u%0d got %b want 0", u, fdn[u]); end
            checks++; if (bcnt[u] !== 16'd0) begin errors++; $display("FAIL reset_count u%0d got %0d want 0", u, bcnt[u]); end
            checks++; if (rdy[u] !== 1'b0) begin errors++; $display("FAIL reset_ready u%0d got %b want 0", u, rdy[u]); end
        end
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", rdy[0]); end
    endtask

    task automatic test_stream_8n1();
        logic [9:0] exp_a5;
        int last;
        exp_a5 = 10'b1101001010;
        @(negedge clk);
        s_data = 8'hA5; s_valid = 1'b1; #1;
        checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL 8n1_ready got %b want 1", rdy[0]); end
        fork
            sample_line(0, 110);
            begin @(negedge clk); s_valid = 1'b0; end
        join
        for (int i = 0; i < 10; i++) begin
            checks++; if (l_tx[i*10 + 5] !== exp_a5[i]) begin errors++; $display("FAIL 8n1_bit%0d got %b want %b", i, l_tx[i*10+5], exp_a5[i]); end
        end
        clear_exp();
        put_frame(8'hA5, 8, 0, 1, 1, last);
        for (int k = 1; k <= 110; k++) begin
            checks++; if (l_tx[k] !== e_tx[k]) begin errors++; $display("FAIL 8n1_line k=%0d got %b want %b", k, l_tx[k], e_tx[k]); end
            checks++; if (l_fd[k] !== (k == 100)) begin errors++; $display("FAIL 8n1_done k=%0d got %b want %b", k, l_fd[k], (k == 100)); end
            checks++; if (l_bsy[k] !== (k <= 100)) begin errors++; $display("FAIL 8n1_busy k=%0d got %b want %b", k, l_bsy[k], (k <= 100)); end
            checks++; if (l_rdy[k] !== (k > 100)) begin errors++; $display("FAIL 8n1_ready k=%0d got %b want %b", k, l_rdy[k], (k > 100)); end
        end
        checks++; if (bcnt[0] !== 16'd1) begin errors++; $display("FAIL 8n1_count got %0d want 1", bcnt[0]); end
    endtask

    task automatic test_back_to_back();
        int last;
        @(negedge clk);
        s_data = 8'h5A; s_valid = 1'b1;
        fork
            sample_line(0, 210);
            begin
                @(negedge clk); s_data = 8'hC3;
                repeat (101) @(negedge clk); s_valid = 1'b0;
            end
        join
        clear_exp();
        put_frame(8'h5A, 8, 0, 1, 1, last);
        put_frame(8'hC3, 8, 0, 1, 102, last);
        for (int k = 1; k <= 210; k++) begin
            checks++; if (l_tx[k] !== e_tx[k]) begin errors++; $display("FAIL b2b_line k=%0d got %b want %b", k, l_tx[k], e_tx[k]); end
            checks++; if (l_fd[k] !== (k == 100 || k == 201)) begin errors++; $display("FAIL b2b_done k=%0d got %b", k, l_fd[k]); end
            checks++; if (l_rdy[k] !== (k == 101 || k > 201)) begin errors++; $display("FAIL b2b_ready k=%0d got %b", k, l_rdy[k]); end
        end
        checks++; if (bcnt[0] !== 16'd3) begin errors++; $display("FAIL b2b_count got %0d want 3", bcnt[0]); end
    endtask

    task automatic test_midframe_reset();
        int last;
        @(negedge clk);
        s_data = 8'hA5; s_valid = 1'b1;
        fork
            sample_line(0, 30);
            begin @(negedge clk); s_valid = 1'b0; end
        join
        checks++; if (l_bsy[30] !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", l_bsy[30]); end
        rst = 1'b1; #1;
        checks++; if (txv[0] !== 1'b1) begin errors++; $display("FAIL mid_rst_tx got %b want 1", txv[0]); end
        checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", bsy[0]); end
        checks++; if (bcnt[0] !== 16'd0) begin errors++; $display("FAIL mid_rst_count got %0d want 0", bcnt[0]); end
        checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", rdy[0]); end
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b want 1", rdy[0]); end
        s_data = 8'h3C; s_valid = 1'b1;
        fork
            sample_line(0, 105);
            begin @(negedge clk); s_valid = 1'b0; end
        join
        clear_exp();
        put_frame(8'h3C, 8, 0, 1, 1, last);
        for (int k = 1; k <= 105; k++) begin
            checks++; if (l_tx[k] !== e_tx[k]) begin errors++; $display("FAIL mid_line k=%0d got %b want %b", k, l_tx[k], e_tx[k]); end
            checks++; if (l_fd[k] !== (k == last)) begin errors++; $display("FAIL mid_done k=%0d got %b", k, l_fd[k]); end
        end
        checks++; if (bcnt[0] !== 16'd1) begin errors++; $display("FAIL mid_count got %0d want 1", bcnt[0]); end
    endtask

    task automatic test_parity();
        int last;
        for (int u = 1; u <= 2; u++) begin
            do_reset();
            @(negedge clk);
            s_data = 8'h03; s_valid = 1'b1;
            fork
                sample_line(u, 125);
                begin @(negedge clk); s_valid = 1'b0; end
            join
            checks++; if (l_tx[95] !== (u == 1)) begin errors++; $display("FAIL par_bit u%0d got %b want %b", u, l_tx[95], (u == 1)); end
            clear_exp();
            put_frame(8'h03, 8, u, 2, 1, last);
            for (int k = 1; k <= 125; k++) begin
                checks++; if (l_tx[k] !== e_tx[k]) begin errors++; $display("FAIL par_line u%0d k=%0d got %b want %b", u, k, l_tx[k], e_tx[k]); end
                checks++; if (l_fd[k] !== (k == 120)) begin errors++; $display("FAIL par_done u%0d k=%0d got %b", u, k, l_fd[k]); end
                checks++; if (l_bsy[k] !== (k <= 120)) begin errors++; $display("FAIL par_busy u%0d k=%0d got %b", u, k, l_bsy[k]); end
            end
        end
    endtask

    task automatic test_pattern();
        int last;
        do_reset();
        @(negedge clk);
        mode = 1'b1; enable = 1'b1; #1;
        checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL pat_ready_idle got %b want 0", rdy[0]); end
        fork
            sample_line(0, 310);
            begin repeat (250) @(negedge clk); enable = 1'b0; end
        join
        clear_exp();
        put_frame(8'h01, 8, 0, 1, 1, last);
        put_frame(8'h02, 8, 0, 1, 102, last);
        put_frame(8'h03, 8, 0, 1, 203, last);
        for (int k = 1; k <= 310; k++) begin
            checks++; if (l_tx[k] !== e_tx[k]) begin errors++; $display("FAIL pat_line k=%0d got %b want %b", k, l_tx[k], e_tx[k]); end
            checks++; if (l_fd[k] !== (k == 100 || k == 201 || k == 302)) begin errors++; $display("FAIL pat_done k=%0d got %b", k, l_fd[k]); end
            checks++; if (l_rdy[k] !== 1'b0) begin errors++; $display("FAIL pat_ready k=%0d got %b want 0", k, l_rdy[k]); end
        end
        checks++; if (bcnt[0] !== 16'd3) begin errors++; $display("FAIL pat_count got %0d want 3", bcnt[0]); end
        mode = 1'b0;
    endtask

    task automatic test_wrap();
        int last;
        do_reset();
        @(negedge clk);
        mode = 1'b1; enable = 1'b1;
        fork
            sample_line(3, 2350);
            begin repeat (2303) @(negedge clk); enable = 1'b0; end
        join
        clear_exp();
        for (int j = 0; j < 33; j++) put_frame(8'((j + 1) % 32), 5, 0, 1, 1 + 71*j, last);
        for (int i = 0; i < 5; i++) begin
            checks++; if (l_tx[2202 + 10*(i+1) + 5] !== 1'b0) begin errors++; $display("FAIL wrap_32nd_bit%0d got %b want 0", i, l_tx[2202 + 10*(i+1) + 5]); end
        end
        checks++; if (l_tx[2273 + 15] !== 1'b1) begin errors++; $display("FAIL wrap_33rd_bit0 got %b want 1", l_tx[2288]); end
        for (int k = 1; k <= 2350; k++) begin
            checks++; if (l_tx[k] !== e_tx[k]) begin errors++; $display("FAIL wrap_line k=%0d got %b want %b", k, l_tx[k], e_tx[k]); end
            checks++; if (l_fd[k] !== ((k % 71 == 70) && k <= 2342)) begin errors++; $display("FAIL wrap_done k=%0d got %b", k, l_fd[k]); end
        end
        checks++; if (bcnt[3] !== 16'd33) begin errors++; $display("FAIL wrap_count got %0d want 33", bcnt[3]); end
        mode = 1'b0;
    endtask

    task automatic test_gap();
        int last;
        do_reset();
        @(negedge clk);
        s_data = 8'h81; s_valid = 1'b1;
        fork
            sample_line(4, 250);
            begin
                @(negedge clk); s_valid = 1'b0;
                repeat (49) @(negedge clk); mode = 1'b1; enable = 1'b1;
                repeat (100) @(negedge clk); enable = 1'b0;
            end
        join
        clear_exp();
        put_frame(8'h81, 8, 0, 1, 1, last);
        put_frame(8'h01, 8, 0, 1, 122, last);
        for (int k = 1; k <= 250; k++) begin
            checks++; if (l_tx[k] !== e_tx[k]) begin errors++; $display("FAIL gap_line k=%0d got %b want %b", k, l_tx[k], e_tx[k]); end
            checks++; if (l_fd[k] !== (k == 120 || k == 241)) begin errors++; $display("FAIL gap_done k=%0d got %b", k, l_fd[k]); end
            checks++; if (l_bsy[k] !== ((k <= 120) || (k >= 122 && k <= 241))) begin errors++; $display("FAIL gap_busy k=%0d got %b", k, l_bsy[k]); end
            checks++; if (l_rdy[k] !== 1'b0) begin errors++; $display("FAIL gap_ready k=%0d got %b want 0", k, l_rdy[k]); end
        end
        checks++; if (bcnt[4] !== 16'd2) begin errors++; $display("FAIL gap_count got %0d want 2", bcnt[4]); end
        mode = 1'b0; enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream_8n1();
        test_back_to_back();
        test_midframe_reset();
        test_parity();
        test_pattern();
        test_wrap();
        test_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
